// File: rtl/tft_char_pkg.sv
// tft_char_pkg: shared glyph geometry, RGB565 type and default colours for the TFT text path
package tft_char_pkg;
    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;
    localparam int ROM_AW = 7;
    typedef logic [15:0] rgb565_t;
    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam rgb565_t FG_DEFAULT = 16'hFFFF;
    localparam rgb565_t BG_DEFAULT = 16'h0000;
endpackage

// File: rtl/char_code_buffer.sv
// char_code_buffer: shadow/active character code registers, active reloaded once per frame
module char_code_buffer
    import tft_char_pkg::*;
#(
    parameter int NUM_CHARS = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      frame_start,
    input  logic                      wr_en,
    input  logic [3:0]                wr_idx,
    input  logic [3:0]                wr_code,
    output logic [NUM_CHARS-1:0][3:0] active
);
    logic [NUM_CHARS-1:0][3:0] shadow;

    // frame_start copies the pre-write shadow, so a same-cycle write lands one frame later
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow <= {NUM_CHARS{BLANK_CODE}};
            active <= {NUM_CHARS{BLANK_CODE}};
        end else begin
            if (frame_start) active <= shadow;
            for (int i = 0; i < NUM_CHARS; i++)
                if (wr_en && wr_idx == 4'(i)) shadow[i] <= wr_code;
        end
    end
endmodule

// File: rtl/char_glyph_renderer.sv
// char_glyph_renderer: maps the scan position onto a text box, drives the glyph ROMs, emits RGB565
module char_glyph_renderer
    import tft_char_pkg::*;
#(
    parameter int      NUM_CHARS  = 8,
    parameter int      NUM_GLYPHS = 10,
    parameter int      ORIGIN_X   = 0,
    parameter int      ORIGIN_Y   = 0,
    parameter int      X_W        = 11,
    parameter int      Y_W        = 10,
    parameter rgb565_t FG         = FG_DEFAULT,
    parameter rgb565_t BG         = BG_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  pix_valid,
    input  logic [X_W-1:0]        pix_x,
    input  logic [Y_W-1:0]        pix_y,
    input  logic                  wr_en,
    input  logic [3:0]            wr_idx,
    input  logic [3:0]            wr_code,
    output logic [ROM_AW-1:0]     rom_address,
    input  logic [NUM_GLYPHS-1:0] rom_q,
    output logic                  rgb_valid,
    output rgb565_t               rgb,
    output logic                  in_box
);
    logic [NUM_CHARS-1:0][3:0] active;
    logic [X_W-1:0] dx;
    logic [Y_W-1:0] dy;
    logic hit;
    logic [3:0] cell_code;
    logic v1, v2, hit1, hit2;
    logic [3:0] code1, code2;
    logic [15:0] q_pad;

    char_code_buffer #(.NUM_CHARS(NUM_CHARS)) u_codes (
        .clock(clock), .reset(reset), .frame_start(frame_start),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_code(wr_code), .active(active)
    );

    assign dx = pix_x - X_W'(ORIGIN_X);
    assign dy = pix_y - Y_W'(ORIGIN_Y);
    assign hit = pix_x >= X_W'(ORIGIN_X) && pix_y >= Y_W'(ORIGIN_Y) &&
                 dx < X_W'(GLYPH_W * NUM_CHARS) && dy < Y_W'(GLYPH_H);
    assign q_pad = 16'(rom_q);

    // pick the active code of the cell under the scan position
    always_comb begin
        cell_code = BLANK_CODE;
        for (int i = 0; i < NUM_CHARS; i++)
            if (dx[6:3] == 4'(i)) cell_code = active[i];
    end

    // S1: issue the ROM address; it holds through pix_valid gaps
    always_ff @(posedge clock) begin
        if (reset) begin
            rom_address <= '0;
            v1 <= 1'b0;
            hit1 <= 1'b0;
            code1 <= BLANK_CODE;
        end else begin
            v1 <= pix_valid;
            hit1 <= pix_valid && hit;
            code1 <= cell_code;
            if (pix_valid) rom_address <= hit ? {dy[3:0], dx[2:0]} : '0;
        end
    end

    // S2: sideband rides alongside the ROM's own output register
    always_ff @(posedge clock) begin
        if (reset) begin
            v2 <= 1'b0;
            hit2 <= 1'b0;
            code2 <= BLANK_CODE;
        end else begin
            v2 <= v1;
            hit2 <= hit1;
            code2 <= code1;
        end
    end

    // S3: select the returned bit for this cell's code; unattached codes render background
    always_ff @(posedge clock) begin
        if (reset) begin
            rgb_valid <= 1'b0;
            in_box <= 1'b0;
            rgb <= BG;
        end else begin
            rgb_valid <= v2;
            in_box <= hit2;
            rgb <= (hit2 && {1'b0, code2} < 5'(NUM_GLYPHS) && q_pad[code2]) ? FG : BG;
        end
    end
endmodule
